// File: rtl/pcie_tx_tlp_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pcie_tx_tlp_fifo
// Description : Store-and-forward TLP FIFO on the 256-bit AXI4-Stream TX path.
//               A TLP becomes visible to the read side only once its tlast
//               beat has been stored, so out_tvalid is continuous inside a
//               packet. Discontinued (tuser[3] on tlast) and oversize TLPs
//               are discarded before they reach the endpoint core.
// Options     : PCIE_TX_FIFO_STATS_EN - when defined, generates the
//               forwarded / dropped packet counters; otherwise both
//               statistics ports are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_tx_tlp_fifo #(
  parameter int DATA_W = 256,
  parameter int KEEP_W = 32,
  parameter int USER_W = 4,
  parameter int DEPTH  = 64
) (
  input  logic                    user_clk,
  input  logic                    user_rst_n,
  input  logic [DATA_W-1:0]       in_tdata,
  input  logic [KEEP_W-1:0]       in_tkeep,
  input  logic                    in_tlast,
  input  logic [USER_W-1:0]       in_tuser,
  input  logic                    in_tvalid,
  output logic                    in_tready,
  output logic [DATA_W-1:0]       out_tdata,
  output logic [KEEP_W-1:0]       out_tkeep,
  output logic                    out_tlast,
  output logic [USER_W-1:0]       out_tuser,
  output logic                    out_tvalid,
  input  logic                    out_tready,
  output logic [$clog2(DEPTH):0]  pkt_count,
  output logic                    err_discont,
  output logic                    err_oversize,
  output logic [31:0]             stat_tx_pkts,
  output logic [31:0]             stat_drop_pkts
);

  localparam int AW       = $clog2(DEPTH);
  localparam int PW       = AW + 1;
  localparam int EW       = DATA_W + KEEP_W + 1 + USER_W;
  localparam int DISC_BIT = 3;

  localparam logic [PW-1:0]     DEPTH_P   = PW'(DEPTH);
  localparam logic [PW-1:0]     PTR_ONE   = PW'(1);
  // The discontinue flag is consumed here and never forwarded to the core.
  localparam logic [USER_W-1:0] USER_MASK = ~(USER_W'(1) << DISC_BIT);

  typedef enum logic [0:0] {
    WR_IDLE = 1'b0,
    WR_DROP = 1'b1
  } wr_state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  wr_state_t           wr_state_q,     wr_state_d;
  logic [PW-1:0]       wr_ptr_q,       wr_ptr_d;
  logic [PW-1:0]       commit_ptr_q,   commit_ptr_d;
  logic [PW-1:0]       rd_ptr_q,       rd_ptr_d;
  logic                ready_en_q,     ready_en_d;
  logic                out_valid_q,    out_valid_d;
  logic [DATA_W-1:0]   out_data_q,     out_data_d;
  logic [KEEP_W-1:0]   out_keep_q,     out_keep_d;
  logic                out_last_q,     out_last_d;
  logic [USER_W-1:0]   out_user_q,     out_user_d;
  logic [PW-1:0]       pkt_count_q,    pkt_count_d;
  logic                err_discont_q,  err_discont_d;
  logic                err_oversize_q, err_oversize_d;

  // Beat storage: {tdata, tkeep, tlast, tuser} per entry.
  logic [EW-1:0]       mem [DEPTH];

  // --------------------------------------------------------------------------
  // Occupancy and handshakes
  // --------------------------------------------------------------------------
  logic [PW-1:0]       occupancy;
  logic [PW-1:0]       part_len;
  logic                fifo_full;
  logic                part_full;
  logic                dropping;
  logic                in_fire;
  logic                mem_we;
  logic                commit;
  logic [PW-1:0]       fetch_ptr;
  logic                rd_avail;
  logic                out_fire;
  logic                out_load;
  logic [EW-1:0]       rd_word;
  logic [DATA_W-1:0]   rd_data;
  logic [KEEP_W-1:0]   rd_keep;
  logic                rd_last;
  logic [USER_W-1:0]   rd_user;

  // rd_ptr marks the head beat that is still owned by the output register,
  // so the slot it occupies stays counted until the core accepts it.
  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign part_len  = wr_ptr_q - commit_ptr_q;
  assign fifo_full = (occupancy == DEPTH_P);
  // A single uncommitted TLP filling every slot can never commit; keep
  // accepting so the oversize drop can be detected instead of deadlocking.
  assign part_full = (part_len == DEPTH_P);
  assign dropping  = (wr_state_q == WR_DROP);
  assign in_tready = ready_en_q & (~fifo_full | dropping | part_full);
  assign in_fire   = in_tvalid & in_tready;

  // Next beat to prefetch sits one past the head when the head is loaded.
  assign fetch_ptr = rd_ptr_q + {{(PW-1){1'b0}}, out_valid_q};
  assign rd_avail  = (fetch_ptr != commit_ptr_q);
  assign out_fire  = out_valid_q & out_tready;
  assign out_load  = rd_avail & (~out_valid_q | out_tready);

  assign rd_word = mem[fetch_ptr[AW-1:0]];
  assign {rd_data, rd_keep, rd_last, rd_user} = rd_word;

  // --------------------------------------------------------------------------
  // Write side: speculative write pointer, commit on good tlast, rewind on drop
  // --------------------------------------------------------------------------
  // Write FSM next-state, pointer updates and error pulses.
  always_comb begin
    wr_state_d     = wr_state_q;
    wr_ptr_d       = wr_ptr_q;
    commit_ptr_d   = commit_ptr_q;
    mem_we         = 1'b0;
    commit         = 1'b0;
    err_discont_d  = 1'b0;
    err_oversize_d = 1'b0;

    if (in_fire) begin
      unique case (wr_state_q)
        WR_IDLE: begin
          if (part_full) begin
            // Beat DEPTH+1 of one TLP: no room to ever hold it.
            wr_ptr_d = commit_ptr_q;
            if (in_tlast) begin
              err_oversize_d = 1'b1;
            end else begin
              wr_state_d = WR_DROP;
            end
          end else begin
            mem_we = 1'b1;
            if (in_tlast && in_tuser[DISC_BIT]) begin
              wr_ptr_d      = commit_ptr_q;
              err_discont_d = 1'b1;
            end else if (in_tlast) begin
              wr_ptr_d     = wr_ptr_q + PTR_ONE;
              commit_ptr_d = wr_ptr_q + PTR_ONE;
              commit       = 1'b1;
            end else begin
              wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
          end
        end
        WR_DROP: begin
          wr_ptr_d = commit_ptr_q;
          if (in_tlast) begin
            err_oversize_d = 1'b1;
            wr_state_d     = WR_IDLE;
          end
        end
        default: begin
          wr_state_d = WR_IDLE;
          wr_ptr_d   = commit_ptr_q;
        end
      endcase
    end
  end

  // Beat storage; contents are don't-care until committed, so no reset.
  always_ff @(posedge user_clk) begin
    if (mem_we) begin
      mem[wr_ptr_q[AW-1:0]] <= {in_tdata, in_tkeep, in_tlast, in_tuser};
    end
  end

  // --------------------------------------------------------------------------
  // Read side: registered output stage refilled on the cycle it drains
  // --------------------------------------------------------------------------
  // Output register, head pointer and committed-packet count.
  always_comb begin
    ready_en_d  = 1'b1;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_user_d  = out_user_q;
    pkt_count_d = pkt_count_q;

    if (out_fire) begin
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
      out_valid_d = 1'b0;
    end

    if (out_load) begin
      out_valid_d = 1'b1;
      out_data_d  = rd_data;
      out_keep_d  = rd_keep;
      out_last_d  = rd_last;
      out_user_d  = rd_user & USER_MASK;
    end

    unique case ({commit, out_fire & out_last_q})
      2'b10:   pkt_count_d = pkt_count_q + PTR_ONE;
      2'b01:   pkt_count_d = pkt_count_q - PTR_ONE;
      default: pkt_count_d = pkt_count_q;
    endcase
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      wr_state_q     <= WR_IDLE;
      wr_ptr_q       <= '0;
      commit_ptr_q   <= '0;
      rd_ptr_q       <= '0;
      ready_en_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_keep_q     <= '0;
      out_last_q     <= 1'b0;
      out_user_q     <= '0;
      pkt_count_q    <= '0;
      err_discont_q  <= 1'b0;
      err_oversize_q <= 1'b0;
    end else begin
      wr_state_q     <= wr_state_d;
      wr_ptr_q       <= wr_ptr_d;
      commit_ptr_q   <= commit_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      ready_en_q     <= ready_en_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_keep_q     <= out_keep_d;
      out_last_q     <= out_last_d;
      out_user_q     <= out_user_d;
      pkt_count_q    <= pkt_count_d;
      err_discont_q  <= err_discont_d;
      err_oversize_q <= err_oversize_d;
    end
  end

  assign out_tdata    = out_data_q;
  assign out_tkeep    = out_keep_q;
  assign out_tlast    = out_last_q;
  assign out_tuser    = out_user_q;
  assign out_tvalid   = out_valid_q;
  assign pkt_count    = pkt_count_q;
  assign err_discont  = err_discont_q;
  assign err_oversize = err_oversize_q;

  // --------------------------------------------------------------------------
  // Optional statistics
  // --------------------------------------------------------------------------
`ifdef PCIE_TX_FIFO_STATS_EN
  logic [31:0] stat_tx_q,   stat_tx_d;
  logic [31:0] stat_drop_q, stat_drop_d;

  // Free-running wrap-around packet counters.
  always_comb begin
    stat_tx_d   = stat_tx_q;
    stat_drop_d = stat_drop_q;
    if (out_fire && out_last_q) begin
      stat_tx_d = stat_tx_q + 32'd1;
    end
    if (err_discont_d || err_oversize_d) begin
      stat_drop_d = stat_drop_q + 32'd1;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      stat_tx_q   <= 32'd0;
      stat_drop_q <= 32'd0;
    end else begin
      stat_tx_q   <= stat_tx_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  assign stat_tx_pkts   = stat_tx_q;
  assign stat_drop_pkts = stat_drop_q;
`else
  assign stat_tx_pkts   = 32'd0;
  assign stat_drop_pkts = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pcie_tx_tlp_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pcie_tx_tlp_fifo
// Description : Self-checking bench for pcie_tx_tlp_fifo. Randomised TLPs are
//               checked against a packet-level model: good TLPs are queued
//               beat by beat once fully accepted, dropped TLPs only add to the
//               expected error pulse counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcie_tx_tlp_fifo;

  localparam int DATA_W = 256;
  localparam int KEEP_W = 32;
  localparam int USER_W = 4;
  localparam int DEPTH  = 64;
  localparam int PCW    = $clog2(DEPTH) + 1;

  logic                user_clk   = 1'b0;
  logic                user_rst_n = 1'b0;
  logic [DATA_W-1:0]   in_tdata   = '0;
  logic [KEEP_W-1:0]   in_tkeep   = '0;
  logic                in_tlast   = 1'b0;
  logic [USER_W-1:0]   in_tuser   = '0;
  logic                in_tvalid  = 1'b0;
  logic                in_tready;
  logic [DATA_W-1:0]   out_tdata;
  logic [KEEP_W-1:0]   out_tkeep;
  logic                out_tlast;
  logic [USER_W-1:0]   out_tuser;
  logic                out_tvalid;
  logic                out_tready = 1'b0;
  logic [PCW-1:0]      pkt_count;
  logic                err_discont;
  logic                err_oversize;
  logic [31:0]         stat_tx_pkts;
  logic [31:0]         stat_drop_pkts;

  pcie_tx_tlp_fifo #(
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W),
    .USER_W (USER_W),
    .DEPTH  (DEPTH)
  ) dut (
    .user_clk       (user_clk),
    .user_rst_n     (user_rst_n),
    .in_tdata       (in_tdata),
    .in_tkeep       (in_tkeep),
    .in_tlast       (in_tlast),
    .in_tuser       (in_tuser),
    .in_tvalid      (in_tvalid),
    .in_tready      (in_tready),
    .out_tdata      (out_tdata),
    .out_tkeep      (out_tkeep),
    .out_tlast      (out_tlast),
    .out_tuser      (out_tuser),
    .out_tvalid     (out_tvalid),
    .out_tready     (out_tready),
    .pkt_count      (pkt_count),
    .err_discont    (err_discont),
    .err_oversize   (err_oversize),
    .stat_tx_pkts   (stat_tx_pkts),
    .stat_drop_pkts (stat_drop_pkts)
  );

  always #5 user_clk = ~user_clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [USER_W-1:0] user;
  } beat_t;

  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc      = 0;
  beat_t exp_q[$];

  // Model counters: exp_tx/exp_drop since last reset, exp_disc/exp_over total.
  int exp_tx = 0, exp_drop = 0, exp_disc = 0, exp_over = 0;
  int last_acc_cyc = 0;

  // Observations gathered by the output monitor.
  int             out_beats       = 0;
  int             disc_pulses     = 0;
  int             over_pulses     = 0;
  int             first_valid_cyc = -1;
  logic [PCW-1:0] pkt_at_first    = '0;
  logic           prev_stall      = 1'b0;
  logic           mid_pkt         = 1'b0;
  beat_t          held;
  beat_t          e;

  always @(posedge user_clk) cyc <= cyc + 1;

  // Output monitor: scoreboard, AXIS hold rule, no gap inside a TLP.
  always @(negedge user_clk) begin
    if (user_rst_n !== 1'b1) begin
      prev_stall = 1'b0;
      mid_pkt    = 1'b0;
    end else begin
      if (err_discont === 1'b1) disc_pulses++;
      if (err_oversize === 1'b1) over_pulses++;
      if (out_tvalid === 1'b1 && first_valid_cyc < 0) begin
        first_valid_cyc = cyc;
        pkt_at_first    = pkt_count;
      end
      if (mid_pkt) begin
        n_checks++;
        if (out_tvalid !== 1'b1) begin
          n_errors++;
          $display("FAIL in_pkt_valid: out_tvalid=%b inside a TLP, required 1 (cycle %0d)", out_tvalid, cyc);
        end
      end
      if (prev_stall) begin
        n_checks++;
        if (out_tvalid !== 1'b1 || out_tdata !== held.data || out_tkeep !== held.keep ||
            out_tlast !== held.last || out_tuser !== held.user) begin
          n_errors++;
          $display("FAIL axis_hold: valid=%b keep=%h last=%b changed while stalled, required keep=%h last=%b (cycle %0d)",
                   out_tvalid, out_tkeep, out_tlast, held.keep, held.last, cyc);
        end
      end
      if (out_tvalid === 1'b1 && out_tready === 1'b1) begin
        n_checks++;
        out_beats++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL scoreboard: unexpected beat data=%h last=%b, required no beat", out_tdata, out_tlast);
        end else begin
          e = exp_q.pop_front();
          if (out_tdata !== e.data || out_tkeep !== e.keep || out_tlast !== e.last || out_tuser !== e.user) begin
            n_errors++;
            $display("FAIL scoreboard: data=%h keep=%h last=%b user=%h, required data=%h keep=%h last=%b user=%h",
                     out_tdata, out_tkeep, out_tlast, out_tuser, e.data, e.keep, e.last, e.user);
          end
        end
        mid_pkt = (out_tlast !== 1'b1);
      end
      prev_stall = (out_tvalid === 1'b1 && out_tready !== 1'b1);
      held.data  = out_tdata;
      held.keep  = out_tkeep;
      held.last  = out_tlast;
      held.user  = out_tuser;
    end
  end

  // Drive one TLP; abort_after>0 stops after that many beats without tlast.
  task automatic send_tlp(input int len, input bit disc, input int gap_pct,
                          input logic [KEEP_W-1:0] last_keep, input int abort_after);
    beat_t pkt[$];
    beat_t x;
    int    waited;
    bit    acc;
    for (int i = 0; i < len; i++) begin
      if (abort_after > 0 && i == abort_after) begin
        in_tvalid = 1'b0;
        return;
      end
      for (int k = 0; k < DATA_W/32; k++) x.data[k*32 +: 32] = $urandom();
      x.last = (i == len - 1);
      x.keep = x.last ? last_keep : {KEEP_W{1'b1}};
      x.user = USER_W'($urandom_range(0, 15));
      if (x.last) x.user[3] = disc;
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        in_tvalid = 1'b0;
        @(posedge user_clk); #1;
      end
      in_tdata  = x.data;
      in_tkeep  = x.keep;
      in_tlast  = x.last;
      in_tuser  = x.user;
      in_tvalid = 1'b1;
      acc    = 1'b0;
      waited = 0;
      while (!acc) begin
        @(negedge user_clk);
        if (in_tready === 1'b1) begin
          acc = 1'b1;
          if (x.last) last_acc_cyc = cyc;
        end else begin
          waited++;
          if (waited > 5000) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: in_tready=%b for %0d cycles, required 1", in_tready, waited);
            @(posedge user_clk); #1;
            in_tvalid = 1'b0;
            return;
          end
        end
        @(posedge user_clk); #1;
      end
      x.user = x.user & 4'b0111;
      pkt.push_back(x);
    end
    in_tvalid = 1'b0;
    if (len > DEPTH) begin
      exp_over++;
      exp_drop++;
    end else if (disc) begin
      exp_disc++;
      exp_drop++;
    end else begin
      foreach (pkt[j]) exp_q.push_back(pkt[j]);
      exp_tx++;
    end
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || out_tvalid === 1'b1) && n < max_cyc) begin
      @(posedge user_clk); #1;
      n++;
    end
    repeat (3) @(posedge user_clk);
    #1;
    n_checks++;
    if (n >= max_cyc) begin
      n_errors++;
      $display("FAIL drain: %0d beats still pending after %0d cycles, required 0", exp_q.size(), max_cyc);
    end
  endtask

  task automatic check_stats(input string tag);
    n_checks++;
`ifdef PCIE_TX_FIFO_STATS_EN
    if (stat_tx_pkts !== 32'(exp_tx) || stat_drop_pkts !== 32'(exp_drop)) begin
      n_errors++;
      $display("FAIL stats_%s: tx=%0d drop=%0d, required tx=%0d drop=%0d", tag, stat_tx_pkts, stat_drop_pkts, exp_tx, exp_drop);
    end
`else
    if (stat_tx_pkts !== 32'd0 || stat_drop_pkts !== 32'd0) begin
      n_errors++;
      $display("FAIL stats_%s: tx=%0d drop=%0d, required 0 0", tag, stat_tx_pkts, stat_drop_pkts);
    end
`endif
  endtask

  task automatic check_err_counts(input string tag);
    n_checks++;
    if (disc_pulses != exp_disc || over_pulses != exp_over) begin
      n_errors++;
      $display("FAIL err_pulses_%s: discont=%0d oversize=%0d, required %0d %0d", tag, disc_pulses, over_pulses, exp_disc, exp_over);
    end
  endtask

  task automatic test_reset();
    user_rst_n = 1'b0;
    in_tvalid  = 1'b0;
    out_tready = 1'b0;
    repeat (3) @(posedge user_clk);
    #1;
    n_checks++;
    if ({in_tready, out_tvalid, out_tlast, err_discont, err_oversize} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: ready=%b valid=%b last=%b errd=%b erro=%b, required all 0",
               in_tready, out_tvalid, out_tlast, err_discont, err_oversize);
    end
    n_checks++;
    if (out_tdata !== '0 || out_tkeep !== '0 || out_tuser !== '0 || pkt_count !== '0) begin
      n_errors++;
      $display("FAIL reset_data: keep=%h user=%h pkt_count=%0d, required 0", out_tkeep, out_tuser, pkt_count);
    end
    check_stats("reset");
    user_rst_n = 1'b1;
    n_checks++;
    if (in_tready !== 1'b0) begin
      n_errors++;
      $display("FAIL ready_before_edge: in_tready=%b, required 0", in_tready);
    end
    @(posedge user_clk); #1;
    n_checks++;
    if (in_tready !== 1'b1) begin
      n_errors++;
      $display("FAIL ready_after_reset: in_tready=%b, required 1", in_tready);
    end
  endtask

  task automatic test_basic();
    int b0 = out_beats;
    out_tready      = 1'b1;
    first_valid_cyc = -1;
    send_tlp(3, 1'b0, 0, 32'h0000_0FFF, 0);
    wait_drain(200);
    n_checks++;
    if (first_valid_cyc - last_acc_cyc != 2) begin
      n_errors++;
      $display("FAIL latency: out_tvalid %0d cycles after tlast, required 2", first_valid_cyc - last_acc_cyc);
    end
    n_checks++;
    if (pkt_at_first !== PCW'(1)) begin
      n_errors++;
      $display("FAIL pkt_count_first: %0d, required 1", pkt_at_first);
    end
    n_checks++;
    if (pkt_count !== '0 || out_beats - b0 != 3) begin
      n_errors++;
      $display("FAIL basic_end: pkt_count=%0d beats=%0d, required 0 and 3", pkt_count, out_beats - b0);
    end
  endtask

  task automatic test_discont();
    int b0 = out_beats;
    out_tready = 1'b1;
    send_tlp(2, 1'b1, 0, '1, 0);
    repeat (6) @(posedge user_clk);
    #1;
    check_err_counts("discont");
    n_checks++;
    if (out_beats != b0) begin
      n_errors++;
      $display("FAIL discont_output: %0d beats forwarded, required 0", out_beats - b0);
    end
    send_tlp(3, 1'b0, 0, 32'h0000_00FF, 0);
    wait_drain(200);
    n_checks++;
    if (out_beats - b0 != 3) begin
      n_errors++;
      $display("FAIL after_discont: %0d beats, required 3", out_beats - b0);
    end
  endtask

  task automatic test_oversize();
    int b0 = out_beats;
    out_tready = 1'b1;
    send_tlp(70, 1'b0, 0, '1, 0);
    repeat (6) @(posedge user_clk);
    #1;
    check_err_counts("over70");
    n_checks++;
    if (out_beats != b0) begin
      n_errors++;
      $display("FAIL oversize_output: %0d beats forwarded, required 0", out_beats - b0);
    end
    send_tlp(65, 1'b0, 0, '1, 0);
    repeat (6) @(posedge user_clk);
    #1;
    check_err_counts("over65");
    send_tlp(2, 1'b0, 0, 32'h0000_000F, 0);
    send_tlp(DEPTH, 1'b0, 0, 32'h0000_FFFF, 0);
    wait_drain(500);
    n_checks++;
    if (out_beats - b0 != 2 + DEPTH) begin
      n_errors++;
      $display("FAIL after_oversize: %0d beats, required %0d", out_beats - b0, 2 + DEPTH);
    end
  endtask

  task automatic test_fill();
    int bubbles = 0;
    out_tready = 1'b0;
    for (int i = 0; i < 16; i++) send_tlp(4, 1'b0, 0, '1, 0);
    repeat (3) @(posedge user_clk);
    #1;
    n_checks++;
    if (in_tready !== 1'b0 || pkt_count !== PCW'(16)) begin
      n_errors++;
      $display("FAIL fill: in_tready=%b pkt_count=%0d, required 0 and 16", in_tready, pkt_count);
    end
    out_tready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge user_clk);
      if (out_tvalid !== 1'b1) bubbles++;
    end
    @(posedge user_clk); #1;
    n_checks++;
    if (bubbles != 0) begin
      n_errors++;
      $display("FAIL fill_bubbles: %0d idle cycles in drain, required 0", bubbles);
    end
    wait_drain(100);
    n_checks++;
    if (pkt_count !== '0) begin
      n_errors++;
      $display("FAIL fill_end: pkt_count=%0d, required 0", pkt_count);
    end
  endtask

  task automatic test_random();
    bit done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          send_tlp($urandom_range(1, 16), ($urandom_range(0, 99) < 5), 20,
                   KEEP_W'($urandom()) | KEEP_W'(1), 0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge user_clk); #1;
          out_tready = ($urandom_range(0, 99) >= 30);
        end
      end
    join
    out_tready = 1'b1;
    wait_drain(2000);
    check_err_counts("random");
    n_checks++;
    if (pkt_count !== '0) begin
      n_errors++;
      $display("FAIL random_end: pkt_count=%0d, required 0", pkt_count);
    end
    check_stats("random");
  endtask

  task automatic test_reset_mid();
    int b0;
    out_tready = 1'b0;
    send_tlp(3, 1'b0, 0, '1, 0);
    send_tlp(3, 1'b0, 0, '1, 0);
    send_tlp(5, 1'b0, 0, '1, 2);
    user_rst_n = 1'b0;
    @(posedge user_clk); #1;
    n_checks++;
    if ({in_tready, out_tvalid, out_tlast, err_discont, err_oversize} !== 5'b0 ||
        out_tdata !== '0 || out_tkeep !== '0 || out_tuser !== '0 || pkt_count !== '0) begin
      n_errors++;
      $display("FAIL mid_reset: ready=%b valid=%b keep=%h pkt_count=%0d, required all 0",
               in_tready, out_tvalid, out_tkeep, pkt_count);
    end
    exp_q.delete();
    exp_tx   = 0;
    exp_drop = 0;
    check_stats("mid_reset");
    user_rst_n = 1'b1;
    @(posedge user_clk); #1;
    out_tready = 1'b1;
    b0 = out_beats;
    send_tlp(2, 1'b0, 0, 32'h0000_3FFF, 0);
    wait_drain(200);
    n_checks++;
    if (out_beats - b0 != 2 || pkt_count !== '0) begin
      n_errors++;
      $display("FAIL post_reset: beats=%0d pkt_count=%0d, required 2 and 0", out_beats - b0, pkt_count);
    end
    check_stats("post_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_discont();
    test_oversize();
    test_fill();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
